// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: free-running H/V counters with a
// registered decode stage gated by a pixel clock-enable.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 10
) (
    input  logic          iClock,
    input  logic          iReset,
    input  logic          iPixEn,
    output logic          oVGA_HS,
    output logic          oVGA_VS,
    output logic          oActive,
    output logic [CW-1:0] oX,
    output logic [CW-1:0] oY,
    output logic          oLineStart,
    output logic          oFrameStart,
    output logic          oVBlank,
    output logic          oPixStb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          line_end;

    assign line_end = (hc == H_LAST);

    // Raster counters; vertical advances only on the last pixel of a line.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            hc <= '0;
            vc <= '0;
        end else if (iPixEn) begin
            if (line_end) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    logic          d_active;
    logic          d_hs;
    logic          d_vs;
    logic          d_vblank;
    logic          d_line;
    logic          d_frame;
    logic [CW-1:0] d_x;
    logic [CW-1:0] d_y;

    // Decode of the current (pre-increment) counter position.
    always_comb begin
        d_active = 1'b0;
        d_hs     = 1'b0;
        d_vs     = 1'b0;
        d_vblank = 1'b0;
        d_line   = 1'b0;
        d_frame  = 1'b0;
        d_x      = '0;
        d_y      = '0;

        d_active = (hc < H_VIS) && (vc < V_VIS);
        d_hs     = (hc >= HS_BEG) && (hc <= HS_END);
        d_vs     = (vc >= VS_BEG) && (vc <= VS_END);
        d_vblank = (vc >= V_VIS);
        d_line   = (hc == '0);
        d_frame  = (hc == '0) && (vc == '0);
        if (d_active) begin
            d_x = hc;
            d_y = vc;
        end
    end

    // Registered outputs: levels hold while disabled, strobes drop so a
    // pulse is never wider than one iClock.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            oVGA_HS     <= ~HS_POL;
            oVGA_VS     <= ~VS_POL;
            oActive     <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oLineStart  <= 1'b0;
            oFrameStart <= 1'b0;
            oVBlank     <= 1'b0;
            oPixStb     <= 1'b0;
        end else if (iPixEn) begin
            oVGA_HS     <= d_hs ? HS_POL : ~HS_POL;
            oVGA_VS     <= d_vs ? VS_POL : ~VS_POL;
            oActive     <= d_active;
            oX          <= d_x;
            oY          <= d_y;
            oLineStart  <= d_line;
            oFrameStart <= d_frame;
            oVBlank     <= d_vblank;
            oPixStb     <= 1'b1;
        end else begin
            oLineStart  <= 1'b0;
            oFrameStart <= 1'b0;
            oPixStb     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 geometry over two lines, plus a tiny
// geometry exercised over full frames, enable gating and mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default-geometry instance
    logic       rst_d, en_d;
    logic       d_hs, d_vs, d_act, d_ls, d_fs, d_vb, d_stb;
    logic [9:0] d_x, d_y;

    vga_timing_gen u_def (
        .iClock(clk), .iReset(rst_d), .iPixEn(en_d),
        .oVGA_HS(d_hs), .oVGA_VS(d_vs), .oActive(d_act),
        .oX(d_x), .oY(d_y), .oLineStart(d_ls), .oFrameStart(d_fs),
        .oVBlank(d_vb), .oPixStb(d_stb)
    );

    // tiny geometry: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), HS active-high
    logic       rst_t, en_t;
    logic       t_hs, t_vs, t_act, t_ls, t_fs, t_vb, t_stb;
    logic [3:0] t_x, t_y;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
    ) u_tiny (
        .iClock(clk), .iReset(rst_t), .iPixEn(en_t),
        .oVGA_HS(t_hs), .oVGA_VS(t_vs), .oActive(t_act),
        .oX(t_x), .oY(t_y), .oLineStart(t_ls), .oFrameStart(t_fs),
        .oVBlank(t_vb), .oPixStb(t_stb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected tiny-instance outputs for position (h,v); on=0 means the
    // previous edge was disabled, so levels hold and strobes are low.
    task automatic chk_t(input int h, input int v, input bit on);
        bit act;
        act = (h < 4) && (v < 3);
        chk($sformatf("t_hs@%0d,%0d", h, v),  t_hs,  (h >= 5 && h <= 6));
        chk($sformatf("t_vs@%0d,%0d", h, v),  t_vs,  !(v == 4));
        chk($sformatf("t_act@%0d,%0d", h, v), t_act, act);
        chk($sformatf("t_x@%0d,%0d", h, v),   t_x,   act ? h : 0);
        chk($sformatf("t_y@%0d,%0d", h, v),   t_y,   act ? v : 0);
        chk($sformatf("t_ls@%0d,%0d", h, v),  t_ls,  on && h == 0);
        chk($sformatf("t_fs@%0d,%0d", h, v),  t_fs,  on && h == 0 && v == 0);
        chk($sformatf("t_vb@%0d,%0d", h, v),  t_vb,  v >= 3);
        chk($sformatf("t_stb@%0d,%0d", h, v), t_stb, on);
    endtask

    task automatic chk_t_reset(input string tag);
        chk({tag, "_hs"},  t_hs,  0);
        chk({tag, "_vs"},  t_vs,  1);
        chk({tag, "_act"}, t_act, 0);
        chk({tag, "_x"},   t_x,   0);
        chk({tag, "_y"},   t_y,   0);
        chk({tag, "_ls"},  t_ls,  0);
        chk({tag, "_fs"},  t_fs,  0);
        chk({tag, "_vb"},  t_vb,  0);
        chk({tag, "_stb"}, t_stb, 0);
    endtask

    task automatic chk_d(input int h, input int v);
        bit act;
        act = (h < 640) && (v < 480);
        chk($sformatf("d_hs@%0d,%0d", h, v),  d_hs,  !(h >= 656 && h <= 751));
        chk($sformatf("d_vs@%0d,%0d", h, v),  d_vs,  !(v >= 490 && v <= 491));
        chk($sformatf("d_act@%0d,%0d", h, v), d_act, act);
        chk($sformatf("d_x@%0d,%0d", h, v),   d_x,   act ? h : 0);
        chk($sformatf("d_y@%0d,%0d", h, v),   d_y,   act ? v : 0);
        chk($sformatf("d_ls@%0d,%0d", h, v),  d_ls,  h == 0);
        chk($sformatf("d_fs@%0d,%0d", h, v),  d_fs,  h == 0 && v == 0);
        chk($sformatf("d_vb@%0d,%0d", h, v),  d_vb,  v >= 480);
        chk($sformatf("d_stb@%0d,%0d", h, v), d_stb, 1);
    endtask

    initial begin
        int h, v, ph, pv;
        int n_ls, n_fs, n_hslow, n_act;

        rst_d = 1'b1; en_d = 1'b0;
        rst_t = 1'b1; en_t = 1'b0;

        // ---- default geometry: reset state, then two full lines ----
        step();
        en_d = 1'b1;
        step();
        chk("d_rst_hs", d_hs, 1);
        chk("d_rst_vs", d_vs, 1);
        chk("d_rst_act", d_act, 0);
        chk("d_rst_ls", d_ls, 0);
        chk("d_rst_fs", d_fs, 0);
        chk("d_rst_stb", d_stb, 0);

        rst_d = 1'b0;
        n_ls = 0; n_hslow = 0; n_act = 0;
        for (int vv = 0; vv < 2; vv++) begin
            for (int hh = 0; hh < 800; hh++) begin
                step();
                chk_d(hh, vv);
                if (d_ls) n_ls++;
                if (!d_hs) n_hslow++;
                if (d_act) n_act++;
            end
        end
        chk("d_line_pulses", n_ls, 2);
        chk("d_hs_low_clocks", n_hslow, 192);
        chk("d_active_clocks", n_act, 1280);
        step();
        chk_d(0, 2);
        en_d = 1'b0;

        // ---- tiny geometry: reset (enable high during reset too) ----
        step();
        chk_t_reset("t_rst0");
        en_t = 1'b1;
        step();
        chk_t_reset("t_rst1");

        // exhaustive full frame from release, then the wrap
        rst_t = 1'b0;
        n_ls = 0; n_fs = 0;
        for (int vv = 0; vv < 6; vv++) begin
            for (int hh = 0; hh < 8; hh++) begin
                step();
                chk_t(hh, vv, 1'b1);
                if (t_ls) n_ls++;
                if (t_fs) n_fs++;
            end
        end
        chk("t_line_pulses", n_ls, 6);
        chk("t_frame_pulses", n_fs, 1);
        step();
        chk_t(0, 0, 1'b1);

        // alternating enable: counters now at (1,0)
        h = 1; v = 0; ph = 0; pv = 0;
        for (int i = 0; i < 16; i++) begin
            en_t = (i % 2 == 0);
            if (en_t) begin
                step();
                chk_t(h, v, 1'b1);
                ph = h; pv = v;
                if (h == 7) begin
                    h = 0;
                    v = (v == 5) ? 0 : v + 1;
                end else begin
                    h = h + 1;
                end
            end else begin
                step();
                chk_t(ph, pv, 1'b0);
            end
        end

        // mid-frame reset from an active pixel
        en_t = 1'b1;
        step();
        chk_t(h, v, 1'b1);
        rst_t = 1'b1;
        step();
        chk_t_reset("t_midrst0");
        step();
        chk_t_reset("t_midrst1");
        rst_t = 1'b0;
        step();
        chk_t(0, 0, 1'b1);
        step();
        chk_t(1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
